zet_exc_seq: RTL and testbench
==============================

Name: zet_exc_seq

Overview:
- Parametrised exception/interrupt sequencer for the Zet core. It is a successor to the fixed trap/divide/external-interrupt logic in the decoder.
- Arbitrates NCH request channels at instruction boundaries and holds the winning channel for the length of its handler microcode.
- Produces the microcode sequence address, including the divide-stall counter, and issues delayed one-cycle acknowledges to external interrupt sources.
- Sits between the opcode decoder (which supplies base_addr) and the microcode ROM.

Parameters:
- AW, 9: microcode address width.
- NCH, 4: number of request channels. Channel 0 has the highest priority.
- SYNC_MASK, 4'b0001: bit i set makes channel i synchronous (captured immediately, never acked).
- DIV_CYC, 18: divide stall reload value.
- ACK_DLY, 2: ack latency in cycles after capture. Must be >= 1.
- REP_OFF, 1: entry offset used when rep is high and rep_sel[ch] is set.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- block  in  1  bus stall; freezes seq and channel state.
- exec_st  in  1  execute state.
- end_seq  in  1  last micro-op of the current sequence.
- div  in  1  divide micro-op in progress.
- wr_ss  in  1  SS write this instruction; inhibits recognition at the next boundary.
- rep  in  1  rep prefix present.
- base_addr  in  AW  decoder entry address.
- req  in  NCH  level requests.
- req_en  in  NCH  per-channel enables (asynchronous channels only).
- entry  in  NCH*AW  packed handler entry addresses; channel i occupies bits [i*AW +: AW].
- rep_sel  in  NCH  channel uses entry+REP_OFF when rep=1.
- seq_addr  out  AW  microcode address.
- active  out  1  a handler sequence is running.
- act_ch  out  NCH  one-hot active channel; all zero when idle.
- ack  out  NCH  one-cycle acknowledge pulse per channel.
- stall  out  1  div_cnt != 0.

Behaviour:
- Reset and clocking: all registers update on posedge clk. When rst=0 at an edge, seq, div_cnt, active, act_ch, en_q, shd, the ack delay line and ack all become 0. Reset mid-handler or mid-ack drops everything with no pending ack.
- Enable latch: en_q <= exec_st ? en_q : req_en.
- Shadow register shd:
  - set to 1 when !exec_st;
  - else cleared when wr_ss;
  - else held.
  - ok = shd & !wr_ss.
- div_cnt (5 bits or more):
  - if div & exec_st: load DIV_CYC when 0, otherwise decrement;
  - else 0.
  - Not gated by block.
- seq priority: reset > block (hold) > end_seq (0) > div_cnt != 0 (hold) > exec_st (seq+1, wraps mod 2^AW) > 0.
- Synchronous capture: evaluated when !block. If (req & SYNC_MASK) != 0, the lowest-index set bit is captured, active=1, in any state. Ignores exec_st, end_seq, ok and req_en. Preempts any active channel.
- Asynchronous capture: requires !block & exec_st & end_seq & ok and no synchronous request. Candidates are req & en_q & ~SYNC_MASK; the lowest index wins.
  - Allowed from IDLE.
  - Allowed from ACTIVE at its end_seq (back-to-back re-entry, act_ch updated).
- ACTIVE->IDLE: on !block & end_seq with no capture.
- block: active and act_ch hold under block.
- seq_addr (combinational): (active ? entry[ch] + (rep & rep_sel[ch] ? REP_OFF : 0) : base_addr) + seq. All sums truncate to AW bits.
- Every capture event, including re-entry, is queued in an NCH-bit ACK_DLY-stage delay line.
- ack[i] is high for exactly one cycle, after edge E0+ACK_DLY, where E0 is the capture edge. Only asynchronous channels are acked (masked by ~SYNC_MASK).
- The delay line is not frozen by block.
- Simultaneous end_seq and a new request at the same edge: the capture wins over the return to IDLE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'hF -> active=0, act_ch=0, ack=0, seq_addr=base_addr.
- Priority and latency: req=4'b1010, en_q=1111, ok=1, exec_st=end_seq=1 at edge E0 -> act_ch=4'b0010 after E0; ack=4'b0010 after E0+2 only; seq_addr=entry[1]+seq.
- Rep entry: rep=1, rep_sel[1]=1, entry[1]=9'h1F0, seq=3 -> seq_addr=9'h1F4. With entry[1]=9'h1FF, seq=1 -> seq_addr=9'h001 (wrap).
- Divide stall: div=1, exec_st=1 for 20 cycles -> seq holds for 18 cycles while stall=1, then advances. A synchronous req[0] pulse mid-stall -> active, act_ch=4'b0001, no ack.
- SS shadow: wr_ss=1 during the instruction with req[2] pending -> no capture at its end_seq. Capture occurs at the following boundary.
- Block/reset: block=1 at the end_seq edge -> no capture and seq held. Assert rst=0 during the ack delay -> ack stays 0 afterwards.

Source files
------------

// File: rtl/zet_exc_seq.sv
// Exception/interrupt sequencer: arbitrates request channels at instruction boundaries,
// generates the microcode address (with divide stall) and delayed acks for async sources.
module zet_exc_seq #(
    parameter int             AW        = 9,
    parameter int             NCH       = 4,
    parameter logic [NCH-1:0] SYNC_MASK = 4'b0001,
    parameter int             DIV_CYC   = 18,
    parameter int             ACK_DLY   = 2,
    parameter int             REP_OFF   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              block,
    input  logic              exec_st,
    input  logic              end_seq,
    input  logic              div,
    input  logic              wr_ss,
    input  logic              rep,
    input  logic [AW-1:0]     base_addr,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    req_en,
    input  logic [NCH*AW-1:0] entry,
    input  logic [NCH-1:0]    rep_sel,
    output logic [AW-1:0]     seq_addr,
    output logic              active,
    output logic [NCH-1:0]    act_ch,
    output logic [NCH-1:0]    ack,
    output logic              stall
);

    localparam int              DW       = ($clog2(DIV_CYC + 1) > 5) ? $clog2(DIV_CYC + 1) : 5;
    localparam logic [DW-1:0]   DIV_LOAD = DW'(DIV_CYC);
    localparam logic [AW-1:0]   REP_W    = AW'(REP_OFF);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state;
    logic [AW-1:0]   seq;
    logic [DW-1:0]   div_cnt;
    logic [NCH-1:0]  en_q;
    logic            shd;
    logic [NCH-1:0]  dly [ACK_DLY];

    logic            ok;
    logic [NCH-1:0]  sync_req;
    logic [NCH-1:0]  async_req;
    logic            cap_sync;
    logic            cap_async;
    logic            capture;
    logic [NCH-1:0]  cap_vec;
    logic [AW-1:0]   sel_entry;
    logic            sel_rep;
    logic [AW-1:0]   start_addr;

    assign active = (state == ACTIVE);
    assign stall  = (div_cnt != '0);

    // Synchronous sources win over everything; async ones only at an unshadowed boundary.
    always_comb begin
        sync_req  = req & SYNC_MASK;
        async_req = req & en_q & ~SYNC_MASK;
        ok        = shd & ~wr_ss;
        cap_sync  = ~block & (|sync_req);
        cap_async = ~block & exec_st & end_seq & ok & ~(|sync_req) & (|async_req);
        capture   = cap_sync | cap_async;
        if (cap_sync)
            cap_vec = sync_req & (-sync_req);
        else if (cap_async)
            cap_vec = async_req & (-async_req);
        else
            cap_vec = '0;
    end

    always_comb begin
        sel_entry = '0;
        sel_rep   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (act_ch[i]) begin
                sel_entry = entry[i*AW +: AW];
                sel_rep   = rep_sel[i];
            end
        end
        if (active)
            start_addr = sel_entry + ((rep & sel_rep) ? REP_W : '0);
        else
            start_addr = base_addr;
        seq_addr = start_addr + seq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            act_ch  <= '0;
            seq     <= '0;
            div_cnt <= '0;
            en_q    <= '0;
            shd     <= 1'b0;
            ack     <= '0;
            for (int k = 0; k < ACK_DLY; k++)
                dly[k] <= '0;
        end else begin
            // The divide counter and ack pipeline keep running through bus stalls.
            if (div & exec_st)
                div_cnt <= (div_cnt == '0) ? DIV_LOAD : div_cnt - DW'(1);
            else
                div_cnt <= '0;

            en_q <= exec_st ? en_q : req_en;
            if (!exec_st)
                shd <= 1'b1;
            else if (wr_ss)
                shd <= 1'b0;

            dly[0] <= cap_vec & ~SYNC_MASK;
            for (int k = 1; k < ACK_DLY; k++)
                dly[k] <= dly[k-1];
            ack <= dly[ACK_DLY-1];

            if (!block) begin
                if (end_seq)
                    seq <= '0;
                else if (div_cnt != '0)
                    seq <= seq;
                else if (exec_st)
                    seq <= seq + AW'(1);
                else
                    seq <= '0;

                if (capture) begin
                    state  <= ACTIVE;
                    act_ch <= cap_vec;
                end else if (end_seq) begin
                    state  <= IDLE;
                    act_ch <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_zet_exc_seq.sv
// Bench for zet_exc_seq: reference model checked every cycle, a table of entry-address
// vectors, hand-written multi-cycle corner sequences and a randomized phase.
module tb_zet_exc_seq;

    localparam int         AW        = 9;
    localparam int         NCH       = 4;
    localparam logic [3:0] SYNC_MASK = 4'b0001;
    localparam int         DIV_CYC   = 18;
    localparam int         ACK_DLY   = 2;
    localparam int         REP_OFF   = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              block;
    logic              exec_st;
    logic              end_seq;
    logic              div;
    logic              wr_ss;
    logic              rep;
    logic [AW-1:0]     base_addr;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    req_en;
    logic [NCH*AW-1:0] entry;
    logic [NCH-1:0]    rep_sel;
    logic [AW-1:0]     seq_addr;
    logic              active;
    logic [NCH-1:0]    act_ch;
    logic [NCH-1:0]    ack;
    logic              stall;
    logic [AW-1:0]     ent [NCH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign entry = {ent[3], ent[2], ent[1], ent[0]};

    zet_exc_seq dut (
        .clk(clk), .rst(rst), .block(block), .exec_st(exec_st), .end_seq(end_seq),
        .div(div), .wr_ss(wr_ss), .rep(rep), .base_addr(base_addr), .req(req),
        .req_en(req_en), .entry(entry), .rep_sel(rep_sel), .seq_addr(seq_addr),
        .active(active), .act_ch(act_ch), .ack(ack), .stall(stall)
    );

    // Reference model state: sequence position, stall count, active channel index,
    // latched enables, shadow flag and a list of acks scheduled by due cycle.
    typedef struct { int due; logic [3:0] mask; } ack_t;
    ack_t       ack_q[$];
    int         m_seq = 0;
    int         m_div = 0;
    int         m_ch = -1;
    bit         m_active = 0;
    bit         m_shd = 0;
    logic [3:0] m_enq = '0;
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic model_edge(output logic [3:0] ea);
        int  cap;
        int  nseq;
        bit  okv;
        ea = '0;
        cyc++;
        if (!rst) begin
            m_seq = 0; m_div = 0; m_active = 0; m_ch = -1; m_enq = '0; m_shd = 0;
            ack_q.delete();
        end else begin
            okv = m_shd && !wr_ss;
            cap = -1;
            if (!block) begin
                for (int i = 0; i < NCH; i++)
                    if (cap < 0 && SYNC_MASK[i] && req[i]) cap = i;
                if (cap < 0 && exec_st && end_seq && okv)
                    for (int i = 0; i < NCH; i++)
                        if (cap < 0 && !SYNC_MASK[i] && req[i] && m_enq[i]) cap = i;
            end
            nseq = m_seq;
            if (!block) begin
                if (end_seq) nseq = 0;
                else if (m_div != 0) nseq = m_seq;
                else if (exec_st) nseq = (m_seq + 1) % (1 << AW);
                else nseq = 0;
            end
            m_seq = nseq;
            m_div = (div && exec_st) ? ((m_div == 0) ? DIV_CYC : m_div - 1) : 0;
            if (!block) begin
                if (cap >= 0) begin
                    m_active = 1; m_ch = cap;
                end else if (end_seq) begin
                    m_active = 0; m_ch = -1;
                end
            end
            if (cap >= 0 && !SYNC_MASK[cap])
                ack_q.push_back('{due: cyc + ACK_DLY, mask: 4'(1 << cap)});
            if (!exec_st) m_enq = req_en;
            if (!exec_st) m_shd = 1;
            else if (wr_ss) m_shd = 0;
        end
        for (int i = ack_q.size() - 1; i >= 0; i--)
            if (ack_q[i].due == cyc) begin
                ea |= ack_q[i].mask;
                ack_q.delete(i);
            end
    endtask

    function automatic logic [AW-1:0] exp_addr();
        int a;
        if (m_active) a = int'(ent[m_ch]) + ((rep && rep_sel[m_ch]) ? REP_OFF : 0);
        else a = int'(base_addr);
        return AW'((a + m_seq) % (1 << AW));
    endfunction

    task automatic step();
        logic [3:0] ea;
        model_edge(ea);
        @(posedge clk);
        #1;
        check("active", 32'(active), 32'(m_active));
        check("act_ch", 32'(act_ch), m_active ? (32'd1 << m_ch) : 32'd0);
        check("ack", 32'(ack), 32'(ea));
        check("stall", 32'(stall), 32'(m_div != 0));
        check("seq_addr", 32'(seq_addr), 32'(exp_addr()));
    endtask

    task automatic idle_inputs();
        block = 0; exec_st = 0; end_seq = 0; div = 0; wr_ss = 0; rep = 0;
        req = '0; req_en = 4'hF; rep_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
    endtask

    typedef struct {
        int             ch;
        logic [AW-1:0]  ent_v;
        logic           rep_v;
        logic           sel_v;
        int             n;
        logic [AW-1:0]  exp_a;
        logic [NCH-1:0] exp_ch;
    } vec_t;
    vec_t vt[6];

    initial begin
        logic [3:0]    ack_or;
        logic [AW-1:0] t;
        int            stall_n;

        vt[0] = '{ch: 1, ent_v: 9'h1F0, rep_v: 1, sel_v: 1, n: 3, exp_a: 9'h1F4, exp_ch: 4'b0010};
        vt[1] = '{ch: 1, ent_v: 9'h1FF, rep_v: 1, sel_v: 1, n: 1, exp_a: 9'h001, exp_ch: 4'b0010};
        vt[2] = '{ch: 1, ent_v: 9'h1F0, rep_v: 0, sel_v: 1, n: 3, exp_a: 9'h1F3, exp_ch: 4'b0010};
        vt[3] = '{ch: 2, ent_v: 9'h0A0, rep_v: 1, sel_v: 0, n: 5, exp_a: 9'h0A5, exp_ch: 4'b0100};
        vt[4] = '{ch: 3, ent_v: 9'h1FE, rep_v: 0, sel_v: 1, n: 4, exp_a: 9'h002, exp_ch: 4'b1000};
        vt[5] = '{ch: 0, ent_v: 9'h100, rep_v: 1, sel_v: 1, n: 2, exp_a: 9'h103, exp_ch: 4'b0001};

        for (int i = 0; i < NCH; i++) ent[i] = AW'($urandom_range(0, 511));
        base_addr = AW'($urandom_range(0, 511));
        idle_inputs();

        // Reset held with all requests asserted.
        rst = 0;
        req = 4'hF;
        for (int i = 0; i < 3; i++) step();
        check("rst_active", 32'(active), 32'd0);
        check("rst_act_ch", 32'(act_ch), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_seq_addr", 32'(seq_addr), 32'(base_addr));
        rst = 1;
        req = '0;

        // Priority and ack latency.
        step();
        req = 4'b1010; exec_st = 1; end_seq = 1;
        step();
        check("prio_act_ch", 32'(act_ch), 32'b0010);
        check("prio_ack_e0", 32'(ack), 32'd0);
        req = '0; end_seq = 0;
        step();
        check("prio_ack_e1", 32'(ack), 32'd0);
        step();
        check("prio_ack_e2", 32'(ack), 32'b0010);
        t = ent[1] + 9'd2;
        check("prio_seq_addr", 32'(seq_addr), 32'(t));
        step();
        check("prio_ack_e3", 32'(ack), 32'd0);

        // Entry address table.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            ent[vt[r].ch] = vt[r].ent_v;
            rep = vt[r].rep_v;
            rep_sel = {NCH{vt[r].sel_v}};
            step();
            exec_st = 1; end_seq = 1; req = 4'(1 << vt[r].ch);
            step();
            req = '0; end_seq = 0;
            for (int k = 0; k < vt[r].n; k++) step();
            check("vec_seq_addr", 32'(seq_addr), 32'(vt[r].exp_a));
            check("vec_act_ch", 32'(act_ch), 32'(vt[r].exp_ch));
        end

        // Divide stall with a synchronous request arriving mid-stall.
        do_reset();
        exec_st = 1; end_seq = 1;
        step();
        end_seq = 0; div = 1;
        stall_n = 0; ack_or = '0;
        for (int i = 0; i < 20; i++) begin
            req = (i == 9) ? 4'b0001 : 4'b0000;
            step();
            if (stall) stall_n++;
            ack_or |= ack;
            if (i == 9) begin
                check("div_sync_active", 32'(active), 32'd1);
                check("div_sync_act_ch", 32'(act_ch), 32'b0001);
            end
        end
        check("div_stall_cycles", 32'(stall_n), 32'd19);
        t = ent[0] + 9'd2;
        check("div_seq_addr", 32'(seq_addr), 32'(t));
        check("div_no_ack", 32'(ack_or), 32'd0);
        div = 0; req = '0;

        // SS write shadows the next boundary.
        do_reset();
        step();
        exec_st = 1; wr_ss = 1; end_seq = 1; req = 4'b0100;
        step();
        check("ss_no_capture", 32'(active), 32'd0);
        wr_ss = 0; exec_st = 0; end_seq = 0;
        step();
        exec_st = 1; end_seq = 1;
        step();
        check("ss_late_capture", 32'(act_ch), 32'b0100);
        req = '0; end_seq = 0;

        // Block at the boundary, then reset during the ack delay.
        do_reset();
        step();
        exec_st = 1;
        for (int i = 0; i < 3; i++) step();
        block = 1; end_seq = 1; req = 4'b0010;
        step();
        check("blk_no_capture", 32'(active), 32'd0);
        t = base_addr + 9'd3;
        check("blk_seq_hold", 32'(seq_addr), 32'(t));
        req = 4'b0011;
        step();
        check("blk_no_sync", 32'(active), 32'd0);
        block = 0; req = 4'b0010;
        step();
        check("blk_release_cap", 32'(act_ch), 32'b0010);
        req = '0; end_seq = 0; rst = 0;
        step();
        rst = 1;
        ack_or = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            ack_or |= ack;
        end
        check("rst_kills_ack", 32'(ack_or), 32'd0);
        check("rst_kills_active", 32'(active), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 63) != 0);
            block     = ($urandom_range(0, 7) == 0);
            exec_st   = ($urandom_range(0, 3) != 0);
            end_seq   = ($urandom_range(0, 3) == 0);
            div       = ($urandom_range(0, 5) == 0) || (div && $urandom_range(0, 15) != 0);
            wr_ss     = ($urandom_range(0, 7) == 0);
            rep       = 1'($urandom_range(0, 1));
            req       = {3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0)};
            req_en    = 4'($urandom_range(0, 15));
            rep_sel   = 4'($urandom_range(0, 15));
            base_addr = AW'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0)
                ent[$urandom_range(0, NCH - 1)] = AW'($urandom_range(0, 511));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
